// File: rtl/tt_logic_seq_pkg.sv
// Shared constants for the sequenced logic unit: opcodes, FSM states and
// TinyTapeout bidirectional pin assignments.
package tt_logic_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_OR     = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_NAND   = 3'd3;
  localparam logic [2:0] OP_ADD    = 3'd4;
  localparam logic [2:0] OP_SUB    = 3'd5;
  localparam logic [2:0] OP_ACCX   = 3'd6;
  localparam logic [2:0] OP_POPCNT = 3'd7;

  localparam int unsigned UIO_LOAD_A  = 7;
  localparam int unsigned UIO_LOAD_B  = 6;
  localparam int unsigned UIO_GO      = 5;
  localparam int unsigned UIO_CLR_ACC = 4;
  localparam int unsigned UIO_BUSY    = 0;
  localparam int unsigned UIO_DONE    = 1;
  localparam int unsigned UIO_CARRY   = 2;
  localparam int unsigned UIO_ZERO    = 3;

  // Step counter must hold WIDTH-1; keep at least one bit for WIDTH=1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/logic_seq_core.sv
// Operand/accumulator registers, IDLE/EXEC sequencer and datapath for the
// eight-operation logic unit; popcount walks one bit of A per cycle.
module logic_seq_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] data_i,
  input  logic [2:0]       opcode_i,
  input  logic             load_a_i,
  input  logic             load_b_i,
  input  logic             go_i,
  input  logic             clr_acc_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             carry_o,
  output logic             zero_o
);
  import tt_logic_seq_pkg::*;

  localparam int unsigned CW  = cnt_width(WIDTH);
  localparam int unsigned PCW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, res_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    count_q;
  logic [PCW-1:0]   pc_q;
  logic             go_q, done_q, carry_q, zero_q;

  logic [WIDTH-1:0] res_d, acc_d;
  logic             carry_d;
  logic [PCW-1:0]   pc_d;
  logic [WIDTH:0]   sum, diff;
  logic             last, go_rise;

  always_comb begin
    sum     = {1'b0, opa_q} + {1'b0, opb_q};
    diff    = {1'b0, opa_q} - {1'b0, opb_q};
    pc_d    = pc_q + PCW'(opa_q[0]);
    res_d   = '0;
    carry_d = 1'b0;
    acc_d   = acc_q;
    case (op_q)
      OP_AND:  res_d = opa_q & opb_q;
      OP_OR:   res_d = opa_q | opb_q;
      OP_XOR:  res_d = opa_q ^ opb_q;
      OP_NAND: res_d = ~(opa_q & opb_q);
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
      end
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
      end
      OP_ACCX: begin
        acc_d = acc_q ^ opa_q;
        res_d = acc_q ^ opa_q;
      end
      default: res_d = WIDTH'(pc_d);
    endcase
    last    = (op_q != OP_POPCNT) || (count_q == CW'(WIDTH - 1));
    go_rise = go_i & ~go_q;
  end

  // Operands are snapshotted at the go edge so a same-edge load does not
  // leak into the running operation; opa_q doubles as the popcount shifter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      count_q <= '0;
      pc_q    <= '0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      go_q   <= go_i;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_a_i)  a_q   <= data_i;
          if (load_b_i)  b_q   <= data_i;
          if (clr_acc_i) acc_q <= '0;
          if (go_rise) begin
            op_q    <= opcode_i;
            opa_q   <= a_q;
            opb_q   <= b_q;
            pc_q    <= '0;
            count_q <= '0;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (last) begin
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= (res_d == '0);
            acc_q   <= acc_d;
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            count_q <= count_q + CW'(1);
            pc_q    <= pc_d;
            opa_q   <= opa_q >> 1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result_o = res_q;
  assign busy_o   = (state_q == ST_EXEC);
  assign done_o   = done_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;

endmodule

// File: rtl/tt_um_logic_seq.sv
// TinyTapeout wrapper: maps tile pins onto logic_seq_core; status bits on the
// low nibble of the bidirectional port, which is permanently output-enabled.
module tt_um_logic_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);
  import tt_logic_seq_pkg::*;

  logic [WIDTH-1:0] result;
  logic             busy, done, carry, zero;

  logic_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .data_i   (ui_in[WIDTH-1:0]),
    .opcode_i (ui_in[2:0]),
    .load_a_i (uio_in[UIO_LOAD_A]),
    .load_b_i (uio_in[UIO_LOAD_B]),
    .go_i     (uio_in[UIO_GO]),
    .clr_acc_i(uio_in[UIO_CLR_ACC]),
    .result_o (result),
    .busy_o   (busy),
    .done_o   (done),
    .carry_o  (carry),
    .zero_o   (zero)
  );

  assign uo_out = 8'(result);

  always_comb begin
    uio_out            = '0;
    uio_out[UIO_BUSY]  = busy;
    uio_out[UIO_DONE]  = done;
    uio_out[UIO_CARRY] = carry;
    uio_out[UIO_ZERO]  = zero;
  end

  assign uio_oe = 8'h0F;

  logic _unused;
  assign _unused = &{1'b0, ena, uio_in[3:0], ui_in};

endmodule

// File: tb/tb_tt_um_logic_seq.sv
// Directed bench for tt_um_logic_seq: an 8-bit instance for the main
// sequence and a 4-bit instance for the narrow-width wrap case.
module tb_tt_um_logic_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = '0, uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] ui4 = '0, uio4 = '0;
  logic [7:0] uo4, uio_out4, uio_oe4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tt_um_logic_seq #(.WIDTH(8)) dut (
    .ui_in(ui_in), .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out),
    .uio_oe(uio_oe), .ena(1'b1), .clk(clk), .rst_n(rst_n)
  );

  tt_um_logic_seq #(.WIDTH(4)) dut4 (
    .ui_in(ui4), .uo_out(uo4), .uio_in(uio4), .uio_out(uio_out4),
    .uio_oe(uio_oe4), .ena(1'b1), .clk(clk), .rst_n(rst_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] strobe, input logic [7:0] val);
    ui_in  = val;
    uio_in = strobe;
    tick();
    uio_in = '0;
  endtask

  // Pulse go with an opcode, then wait (bounded) for done and check latency.
  task automatic do_op(input string tag, input logic [2:0] op, input int n_exp);
    int cyc;
    ui_in  = {5'b0, op};
    uio_in = 8'h20;
    tick();
    uio_in = '0;
    cyc = 0;
    while (!uio_out[1] && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, n_exp);
  endtask

  task automatic done_drops(input string tag);
    tick();
    check({tag, "_done_low"}, {30'b0, uio_out[1:0]}, 0);
  endtask

  initial begin
    int cnt, dones;

    // Reset state
    tick(); tick();
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'h0F);
    #2 rst_n = 1'b1;
    tick();

    // AND of complementary operands
    load(8'h80, 8'hC5);
    load(8'h40, 8'h3A);
    do_op("and", 3'd0, 1);
    check("and_res", uo_out, 8'h00);
    check("and_flags", uio_out, 8'h0A);
    done_drops("and");

    // Arithmetic
    load(8'h80, 8'hF0);
    load(8'h40, 8'h20);
    do_op("add", 3'd4, 1);
    check("add_res", uo_out, 8'h10);
    check("add_flags", uio_out, 8'h06);
    done_drops("add");
    do_op("sub", 3'd5, 1);
    check("sub_res", uo_out, 8'hD0);
    check("sub_flags", uio_out, 8'h02);
    load(8'h80, 8'h20);
    load(8'h40, 8'hF0);
    do_op("subb", 3'd5, 1);
    check("subb_res", uo_out, 8'h30);
    check("subb_flags", uio_out, 8'h06);

    // Popcount with go and loads strobed mid-run
    load(8'h80, 8'hB7);
    ui_in  = 8'h07;
    uio_in = 8'h20;
    tick();
    uio_in = '0;
    cnt = 0;
    while (uio_out[0] && cnt < 20) begin
      cnt++;
      if (cnt == 3) begin
        ui_in  = 8'hFF;
        uio_in = 8'hE0;
      end else begin
        uio_in = '0;
      end
      tick();
    end
    uio_in = '0;
    check("pop_busy_cycles", cnt, 8);
    check("pop_res", uo_out, 8'h06);
    check("pop_done", {31'b0, uio_out[1]}, 1);
    done_drops("pop");
    do_op("pop_keepA", 3'd0, 1);
    check("pop_keepA_res", uo_out, 8'hB0);

    // Accumulator
    load(8'h10, 8'h00);
    load(8'h80, 8'h5A);
    do_op("accx1", 3'd6, 1);
    check("accx1_res", uo_out, 8'h5A);
    load(8'h80, 8'h0F);
    do_op("accx2", 3'd6, 1);
    check("accx2_res", uo_out, 8'h55);
    load(8'h10, 8'h00);
    load(8'h80, 8'h00);
    do_op("accx3", 3'd6, 1);
    check("accx3_res", uo_out, 8'h00);
    check("accx3_flags", uio_out, 8'h0A);

    // Go held high: one operation only
    ui_in  = 8'h00;
    uio_in = 8'h20;
    dones  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (uio_out[1]) dones++;
    end
    uio_in = '0;
    tick();
    check("held_go_dones", dones, 1);

    // Same-edge load and go: XOR uses the old A, the load still lands
    load(8'h80, 8'hFF);
    ui_in  = 8'h0A;
    uio_in = 8'hA0;
    tick();
    uio_in = '0;
    cnt = 0;
    while (!uio_out[1] && cnt < 20) begin
      tick();
      cnt++;
    end
    check("same_edge_latency", cnt, 1);
    check("same_edge_res", uo_out, 8'h0F);
    tick();
    do_op("after_load", 3'd2, 1);
    check("after_load_res", uo_out, 8'hFA);

    // Reset during cycle 4 of a popcount
    load(8'h80, 8'hB7);
    ui_in  = 8'h07;
    uio_in = 8'h20;
    tick();
    uio_in = '0;
    tick(); tick(); tick();
    check("pre_rst_busy", {31'b0, uio_out[0]}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_uo", uo_out, 8'h00);
    check("midrst_uio", uio_out, 8'h00);
    #2 rst_n = 1'b1;
    tick();
    do_op("post_rst_or", 3'd1, 1);
    check("post_rst_res", uo_out, 8'h00);
    check("post_rst_flags", uio_out, 8'h0A);

    // WIDTH=4 instance
    ui4 = 8'h0F; uio4 = 8'h80; tick();
    ui4 = 8'h01; uio4 = 8'h40; tick();
    ui4 = 8'h04; uio4 = 8'h20; tick();
    uio4 = '0;
    tick();
    check("w4_add_res", uo4, 8'h00);
    check("w4_add_flags", uio_out4, 8'h0E);
    ui4 = 8'hF7; uio4 = 8'h80; tick();
    ui4 = 8'hA5; uio4 = 8'h40; tick();
    ui4 = 8'hF4; uio4 = 8'h20; tick();
    uio4 = '0;
    tick();
    check("w4_add2_res", uo4, 8'h0C);
    check("w4_add2_flags", uio_out4, 8'h02);
    check("w4_oe", uio_oe4, 8'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
